// File: rtl/neg_capture_serializer.sv
// neg_capture_serializer: MSB-first serializer launching on rising CLK for negedge-capture receivers.
// Define NEG_CAPTURE_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module neg_capture_serializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             LOAD_VALID,
    input  logic [WIDTH-1:0] D,
    output logic             LOAD_READY,
    output logic             SDO,
    output logic             FRAME,
    output logic             BUSY
);
    localparam logic [2:0] INIT   = 3'd0;
    localparam logic [2:0] IDLE   = 3'd1;
    localparam logic [2:0] SHIFT  = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
`ifdef NEG_CAPTURE_SERIALIZER_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sdo_q, sdo_d;
    logic             frame_q, frame_d;
    logic             ready_q, busy_q;
`ifdef NEG_CAPTURE_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        sdo_d   = 1'b0;
        frame_d = 1'b0;
`ifdef NEG_CAPTURE_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            INIT: state_d = IDLE;
            IDLE: if (LOAD_VALID) begin
                state_d = SHIFT;
                sh_d    = D;
                cnt_d   = '0;
                sdo_d   = D[WIDTH-1];
                frame_d = 1'b1;
`ifdef NEG_CAPTURE_SERIALIZER_PARITY_EN
                par_d   = ^D;
`endif
            end
            SHIFT: if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef NEG_CAPTURE_SERIALIZER_PARITY_EN
                state_d = PARITY;
                sdo_d   = par_q;
                frame_d = 1'b1;
`else
                state_d = GAP;
`endif
            end else begin
                // sh_q[WIDTH-1] is already on SDO, so the next bit sits one below it
                sh_d    = sh_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                sdo_d   = sh_q[WIDTH-2];
                frame_d = 1'b1;
            end
`ifdef NEG_CAPTURE_SERIALIZER_PARITY_EN
            PARITY: state_d = GAP;
`endif
            GAP:     state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= INIT;
            sh_q    <= '0;
            cnt_q   <= '0;
            sdo_q   <= 1'b0;
            frame_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`ifdef NEG_CAPTURE_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            sdo_q   <= sdo_d;
            frame_q <= frame_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
`ifdef NEG_CAPTURE_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign LOAD_READY = ready_q;
    assign SDO        = sdo_q;
    assign FRAME      = frame_q;
    assign BUSY       = busy_q;
endmodule

// File: tb/tb_neg_capture_serializer.sv
// tb_neg_capture_serializer: directed checks of framing, handshake, async reset and optional parity.
module tb_neg_capture_serializer;
`ifdef NEG_CAPTURE_SERIALIZER_PARITY_EN
    localparam int SPACING = 11;
`else
    localparam int SPACING = 10;
`endif
    logic       CLK = 1'b0;
    logic       R = 1'b0;
    logic       LOAD_VALID = 1'b0;
    logic [7:0] D = 8'h00;
    logic       LOAD_READY, SDO, FRAME, BUSY;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         a1, a2;
    logic [7:0] w;

    neg_capture_serializer #(.WIDTH(8), .CNT_W(5)) dut (
        .CLK(CLK), .R(R), .LOAD_VALID(LOAD_VALID), .D(D),
        .LOAD_READY(LOAD_READY), .SDO(SDO), .FRAME(FRAME), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge just after the accept edge; returns at the negedge after the GAP edge.
    task automatic frame_chk(input logic [7:0] fw, input int inj);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge CLK);
            if (i == inj) begin
                D = 8'h00;
                LOAD_VALID = 1'b1;
            end else if (i == inj + 1) LOAD_VALID = 1'b0;
            chk("sdo_bit", SDO, fw[7-i]);
            chk("frame_high", FRAME, 1);
            chk("busy_frame", BUSY, 1);
        end
`ifdef NEG_CAPTURE_SERIALIZER_PARITY_EN
        @(negedge CLK);
        chk("parity_sdo", SDO, ^fw);
        chk("parity_frame", FRAME, 1);
`endif
        @(negedge CLK);
        chk("gap_frame", FRAME, 0);
        chk("gap_sdo", SDO, 0);
        chk("gap_ready", LOAD_READY, 0);
        chk("gap_busy", BUSY, 1);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_sdo", SDO, 0);
        chk("rst_frame", FRAME, 0);
        chk("rst_ready", LOAD_READY, 0);
        chk("rst_busy", BUSY, 1);
        R = 1'b1;
        @(negedge CLK);
        chk("init_ready", LOAD_READY, 1);
        chk("init_busy", BUSY, 0);
        chk("idle_frame", FRAME, 0);

        D = 8'hA5;
        LOAD_VALID = 1'b1;
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        a1 = cyc;
        chk("acc_ready", LOAD_READY, 0);
        frame_chk(8'hA5, 99);
        @(negedge CLK);
        chk("ret_ready", LOAD_READY, 1);
        chk("ret_busy", BUSY, 0);
        chk("ready_latency", cyc - a1, SPACING - 1);

        D = 8'h3C;
        LOAD_VALID = 1'b1;
        @(negedge CLK);
        a1 = cyc;
        D = 8'hFF;
        frame_chk(8'h3C, 99);
        @(negedge CLK);
        chk("b2b_idle_frame", FRAME, 0);
        @(negedge CLK);
        a2 = cyc;
        LOAD_VALID = 1'b0;
        chk("b2b_spacing", a2 - a1, SPACING);
        frame_chk(8'hFF, 99);
        @(negedge CLK);
        chk("b2b_ready", LOAD_READY, 1);

        D = 8'hA5;
        LOAD_VALID = 1'b1;
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        frame_chk(8'hA5, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("no_extra_frame", FRAME, 0);
            chk("no_extra_ready", LOAD_READY, 1);
        end

        w = 8'hF0;
        D = w;
        LOAD_VALID = 1'b1;
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge CLK);
            chk("pre_rst_sdo", SDO, w[7-i]);
        end
        #2 R = 1'b0;
        #1;
        chk("async_frame", FRAME, 0);
        chk("async_sdo", SDO, 0);
        chk("async_ready", LOAD_READY, 0);
        chk("async_busy", BUSY, 1);
        repeat (2) @(negedge CLK);
        R = 1'b1;
        chk("held_ready", LOAD_READY, 0);
        @(negedge CLK);
        chk("rec_ready", LOAD_READY, 1);
        chk("rec_busy", BUSY, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("no_residual_frame", FRAME, 0);
            chk("no_residual_sdo", SDO, 0);
        end

`ifdef NEG_CAPTURE_SERIALIZER_PARITY_EN
        D = 8'h07;
        LOAD_VALID = 1'b1;
        @(negedge CLK);
        a1 = cyc;
        D = 8'h03;
        frame_chk(8'h07, 99);
        @(negedge CLK);
        @(negedge CLK);
        a2 = cyc;
        LOAD_VALID = 1'b0;
        chk("par_spacing", a2 - a1, 11);
        frame_chk(8'h03, 99);
        @(negedge CLK);
        chk("par_ready", LOAD_READY, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
